// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter and sequencer sharing one external DATA_W-bit adder among NUM_REQ requesters.
// Latency: request accepted in cycle t, response valid from t+2; at least 3 cycles per operation.
// Backpressure: one op in flight; rsp stall holds the sum and blocks every requester. Define ADDER_ARB_OVF_EN for o_rsp_ovf.
module adder_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_a,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_b,
    output logic [NUM_REQ-1:0]        o_rsp_valid,
    input  logic [NUM_REQ-1:0]        i_rsp_ready,
    output logic [DATA_W-1:0]         o_rsp_sum,
    output logic [DATA_W-1:0]         o_add_a,
    output logic [DATA_W-1:0]         o_add_b,
    input  logic [DATA_W-1:0]         i_add_sum,
`ifdef ADDER_ARB_OVF_EN
    output logic                      o_rsp_ovf,
`endif
    output logic                      o_busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    logic [DATA_W-1:0]  add_a_q, add_a_d;
    logic [DATA_W-1:0]  add_b_q, add_b_d;
    logic [DATA_W-1:0]  sum_q, sum_d;
`ifdef ADDER_ARB_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W:0]     cand;

    // Round-robin search: walk from ptr downward in offset order so the
    // smallest offset from ptr is the last (winning) assignment.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = ptr_q;
        cand     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (i_req_valid[cand[IDX_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[IDX_W-1:0];
            end
        end
    end

    // Next-state and handshake outputs for the IDLE -> ISSUE -> RESP sequence.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        sum_d       = sum_q;
`ifdef ADDER_ARB_OVF_EN
        ovf_d       = ovf_q;
`endif
        o_req_ready = '0;
        o_rsp_valid = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    o_req_ready[pick_idx] = 1'b1;
                    gnt_d   = pick_idx;
                    add_a_d = i_req_a[pick_idx*DATA_W +: DATA_W];
                    add_b_d = i_req_b[pick_idx*DATA_W +: DATA_W];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Adder is combinational on the registered operands; capture now.
                sum_d = i_add_sum;
`ifdef ADDER_ARB_OVF_EN
                ovf_d = (add_a_q[DATA_W-1] == add_b_q[DATA_W-1]) &&
                        (i_add_sum[DATA_W-1] != add_a_q[DATA_W-1]);
`endif
                state_d = ST_RESP;
            end
            ST_RESP: begin
                o_rsp_valid[gnt_q] = 1'b1;
                if (i_rsp_ready[gnt_q]) begin
                    ptr_d   = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + IDX_W'(1);
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointer and datapath registers; reset discards any op in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            add_a_q <= '0;
            add_b_q <= '0;
            sum_q   <= '0;
`ifdef ADDER_ARB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            add_a_q <= add_a_d;
            add_b_q <= add_b_d;
            sum_q   <= sum_d;
`ifdef ADDER_ARB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign o_add_a   = add_a_q;
    assign o_add_b   = add_b_q;
    assign o_rsp_sum = sum_q;
    assign o_busy    = (state_q != ST_IDLE);
`ifdef ADDER_ARB_OVF_EN
    assign o_rsp_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Self-checking bench for adder_rr_arbiter: directed scenarios plus randomized ops
// against a transaction-level model (round-robin pointer, modular sum, signed-overflow range test).
// Inputs driven on the falling edge; outputs sampled 1 time unit later.
module tb_adder_rr_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic [N-1:0]   i_req_valid;
    logic [N-1:0]   o_req_ready;
    logic [N*W-1:0] i_req_a;
    logic [N*W-1:0] i_req_b;
    logic [N-1:0]   o_rsp_valid;
    logic [N-1:0]   i_rsp_ready;
    logic [W-1:0]   o_rsp_sum;
    logic [W-1:0]   o_add_a;
    logic [W-1:0]   o_add_b;
    logic [W-1:0]   i_add_sum;
    logic           o_busy;
`ifdef ADDER_ARB_OVF_EN
    logic           o_rsp_ovf;
`endif

    int          errs   = 0;
    int          checks = 0;
    int          model_ptr = 0;
    logic [W-1:0] op_a [N];
    logic [W-1:0] op_b [N];
    int          grant_log [$];

    always #5 i_clk = ~i_clk;

    // Stand-in for the shared carry-lookahead adder.
    assign i_add_sum = o_add_a + o_add_b;

    adder_rr_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_a     (i_req_a),
        .i_req_b     (i_req_b),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_sum   (o_rsp_sum),
        .o_add_a     (o_add_a),
        .o_add_b     (o_add_b),
        .i_add_sum   (i_add_sum),
`ifdef ADDER_ARB_OVF_EN
        .o_rsp_ovf   (o_rsp_ovf),
`endif
        .o_busy      (o_busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // First valid requester at or after p, wrapping; -1 when none.
    function automatic int rr_pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) begin
            if (m[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic drive_ops();
        for (int k = 0; k < N; k++) begin
            i_req_a[k*W +: W] = op_a[k];
            i_req_b[k*W +: W] = op_b[k];
        end
    endtask

    task automatic rand_ops();
        for (int k = 0; k < N; k++) begin
            op_a[k] = $urandom;
            op_b[k] = $urandom;
        end
    endtask

    // One full transaction: IDLE grant, ISSUE, RESP with bp stall cycles.
    task automatic do_op(input logic [N-1:0] mask, input int bp, input bit rst_in_issue, output int g);
        logic [W-1:0] exp_sum;
        logic [N-1:0] r;
        longint       s;
        longint       lim;
        bit           exp_ovf;
        lim = 64'd2147483648;
        @(negedge i_clk);
        i_req_valid = mask;
        drive_ops();
        i_rsp_ready = N'($urandom);
        #1;
        g = rr_pick(mask, model_ptr);
        chk("idle_busy", o_busy, 0);
        chk("idle_rsp_valid", o_rsp_valid, 0);
        chk("req_ready", o_req_ready, (g < 0) ? 0 : (1 << g));
        if (g < 0) return;
        // ISSUE cycle
        @(negedge i_clk);
        i_req_valid = mask & ~N'(1 << g);
        i_rsp_ready = N'($urandom);
        if (rst_in_issue) i_rst = 1'b1;
        #1;
        if (rst_in_issue) begin
            chk("rst_busy", o_busy, 0);
            chk("rst_rsp_valid", o_rsp_valid, 0);
            chk("rst_add_a", o_add_a, 0);
            model_ptr = 0;
            @(negedge i_clk);
            i_rst = 1'b0;
            i_req_valid = '0;
            for (int c = 0; c < 4; c++) begin
                @(negedge i_clk);
                #1;
                chk("post_rst_rsp_valid", o_rsp_valid, 0);
                chk("post_rst_busy", o_busy, 0);
            end
            return;
        end
        chk("issue_busy", o_busy, 1);
        chk("issue_req_ready", o_req_ready, 0);
        chk("issue_rsp_valid", o_rsp_valid, 0);
        chk("issue_add_a", o_add_a, op_a[g]);
        chk("issue_add_b", o_add_b, op_b[g]);
        exp_sum = op_a[g] + op_b[g];
        s = longint'($signed(op_a[g])) + longint'($signed(op_b[g]));
        exp_ovf = (s >= lim) || (s < -lim);
        // RESP cycles: granted requester withholds ready for bp cycles
        for (int c = 0; c <= bp; c++) begin
            @(negedge i_clk);
            r = N'($urandom);
            r[g] = (c == bp);
            i_rsp_ready = r;
            #1;
            chk("rsp_valid", o_rsp_valid, 1 << g);
            chk("rsp_sum", o_rsp_sum, exp_sum);
            chk("resp_req_ready", o_req_ready, 0);
            chk("resp_busy", o_busy, 1);
            chk("resp_add_a_hold", o_add_a, op_a[g]);
`ifdef ADDER_ARB_OVF_EN
            chk("rsp_ovf", o_rsp_ovf, exp_ovf);
`else
            if (exp_ovf && c > N) $display("note: overflow case exercised");
`endif
        end
        model_ptr = (g + 1) % N;
        grant_log.push_back(g);
    endtask

    int g;
    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        i_rst       = 1'b1;
        i_req_valid = '0;
        i_rsp_ready = '0;
        i_req_a     = '0;
        i_req_b     = '0;
        for (int k = 0; k < N; k++) begin
            op_a[k] = '0;
            op_b[k] = '0;
        end
        #1;
        chk("reset_busy", o_busy, 0);
        chk("reset_rsp_sum", o_rsp_sum, 0);
        @(negedge i_clk);
        i_rst = 1'b0;

        // Idle after reset
        for (int c = 0; c < 20; c++) begin
            @(negedge i_clk);
            #1;
            chk("idle20_busy", o_busy, 0);
            chk("idle20_ready", o_req_ready, 0);
            chk("idle20_rsp_valid", o_rsp_valid, 0);
            chk("idle20_add", {o_add_a, o_add_b}, 0);
        end

        // Single request from requester 1
        op_a[1] = 32'h0000_0005;
        op_b[1] = 32'h0000_0007;
        do_op(4'b0010, 0, 1'b0, g);
        chk("single_gnt", g, 1);

        // Wrap-around and signed-overflow operands
        op_a[2] = 32'hFFFF_FFFF;
        op_b[2] = 32'h0000_0001;
        do_op(4'b0100, 0, 1'b0, g);
        chk("wrap_gnt", g, 2);
        op_a[3] = 32'h7FFF_FFFF;
        op_b[3] = 32'h0000_0001;
        do_op(4'b1000, 1, 1'b0, g);
        chk("ovf_gnt", g, 3);

        // Fairness: all valid, response always accepted
        rand_ops();
        for (int i = 0; i < 5; i++) begin
            do_op(4'b1111, 0, 1'b0, g);
            chk("fair_order", g, exp_order[i]);
        end

        // Long response backpressure while everybody else waits
        rand_ops();
        do_op(4'b1111, 10, 1'b0, g);
        do_op(4'b0000, 0, 1'b0, g);

        // Reset during ISSUE: pointer returns to 0
        do_op(4'b0100, 0, 1'b0, g);
        chk("pre_rst_gnt", g, 2);
        do_op(4'b1000, 0, 1'b1, g);
        do_op(4'b1100, 0, 1'b0, g);
        chk("post_rst_gnt", g, 2);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            rand_ops();
            do_op(N'($urandom_range(0, 15)), $urandom_range(0, 3), 1'b0, g);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
